chan_mem_model: RTL
===================

# chan_mem_model

Synthesizable, parametrised multi-channel memory model for GPU-level benches and FPGA bring-up, replacing the behavioural memory class used in the matadd/matmul benches. It serves `CHANNELS` independent read/write ports using the GPU's valid/ready memory handshake, with a configurable fixed response latency per request. A backdoor load/peek port preloads program or data images and reads back results without disturbing channel traffic.

## Interface
- `ADDR_BITS`, 8, address width; array depth 2**ADDR_BITS.
- `DATA_BITS`, 8, word width (16 for program memory).
- `CHANNELS`, 4, number of independent request channels, ≥1.
- `LATENCY`, 2, cycles from request acceptance to `ready`, ≥1.
- `clk` in 1, single clock, all logic on rising edge.
- `reset` in 1, synchronous, active-high; clears channel state, not array contents.
- `read_valid` in CHANNELS, per-channel read request.
- `read_address` in CHANNELS×ADDR_BITS, read address per channel.
- `read_ready` out CHANNELS, one-cycle read response strobe.
- `read_data` out CHANNELS×DATA_BITS, read data, valid while `read_ready`=1.
- `write_valid` in CHANNELS, per-channel write request.
- `write_address` in CHANNELS×ADDR_BITS, write address.
- `write_data` in CHANNELS×DATA_BITS, write data.
- `write_ready` out CHANNELS, one-cycle write completion strobe.
- `load_en` in 1, backdoor write enable.
- `load_addr` in ADDR_BITS, backdoor address (shared by load and peek).
- `load_data` in DATA_BITS, backdoor write data.
- `peek_data` out DATA_BITS, combinational array[`load_addr`].

## Operation
- Per-channel FSM: IDLE → WAIT → RESP → DRAIN → IDLE.
- IDLE: if `read_valid` high, latch address, op=READ, go WAIT; else if `write_valid` high, latch address/data, op=WRITE, go WAIT. Read has priority when both are high; the write remains pending.
- WAIT: counter counts LATENCY-1 down to 0; at the edge leaving WAIT the access commits (read samples array, write updates array), and the FSM goes to RESP. LATENCY=1 uses zero WAIT cycles (IDLE commits directly to RESP).
- RESP: the matching `*_ready` is high for exactly one cycle; `read_data` holds the committed value. Next state DRAIN.
- DRAIN: stay until the request's valid is low, then IDLE. Valid held high through DRAIN is never treated as a new request.
- Same-edge commits: writes are applied in ascending channel order, so the highest channel index wins on the same address. A read committing on the same edge as a write to its address returns the old value. `load_en` is applied after all channel writes and wins over them.
- Addresses and data are taken modulo their widths; no out-of-range condition exists.
- Reset: all FSMs IDLE; `read_ready`/`write_ready` = 0; `read_data` = 0; stats counters = 0. Any in-flight access is dropped without commit. Array contents are preserved.

## Timing
- Request first seen in IDLE during cycle N: `*_ready` is high during cycle N+LATENCY.
- The next request on the same channel is accepted no earlier than the first IDLE cycle after valid drops. Minimum period per channel is LATENCY+2 cycles.
- Channels are fully independent; there is no cross-channel stall.
- `peek_data` is combinational. A load issued in cycle N is visible to peek in cycle N+1.

## Configuration
- `CHAN_MEM_STATS_EN` defined: adds output ports `reads_committed` [15:0] and `writes_committed` [15:0]. Each is the saturating count (stops at 16'hFFFF) of channel commits, summed over all channels on the same edge with saturation. Backdoor loads are not counted. Both reset to 0.
- `CHAN_MEM_STATS_EN` undefined: the ports and counters are absent.

## Test plan
- LATENCY=2, preload addr 5=0x2A, ch0 read addr 5 held valid: `read_ready[0]` high exactly in cycle N+2 with data 0x2A; no second response while valid is held.
- ch1 write addr 16=0x07 then backdoor peek addr 16 → `peek_data`=0x07; `write_ready[1]` is a single-cycle pulse at N+2.
- All 4 channels read different addresses in the same cycle → four `read_ready` pulses in the same cycle with correct data.
- ch0 and ch3 write addr 9 (0x11, 0x33) on the same edge while ch2 reads addr 9 → array=0x33, ch2 gets the old value.
- Reset asserted mid-WAIT on a write to addr 3 (old 0x01) → no `write_ready`, addr 3 stays 0x01, FSM accepts a new request after reset.
- Stats build: 8 reads + 8 writes (matadd pattern) → `reads_committed`=8, `writes_committed`=8; after reset both are 0.

Source files
------------

// File: rtl/chan_mem_model.sv
// Multi-channel memory model: per-channel valid/ready ports with fixed response latency and a backdoor load/peek port.
// Optional commit statistics ports are added when CHAN_MEM_STATS_EN is defined.
module chan_mem_model #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 8,
    parameter int CHANNELS  = 4,
    parameter int LATENCY   = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [CHANNELS-1:0]            read_valid,
    input  logic [CHANNELS*ADDR_BITS-1:0]  read_address,
    output logic [CHANNELS-1:0]            read_ready,
    output logic [CHANNELS*DATA_BITS-1:0]  read_data,
    input  logic [CHANNELS-1:0]            write_valid,
    input  logic [CHANNELS*ADDR_BITS-1:0]  write_address,
    input  logic [CHANNELS*DATA_BITS-1:0]  write_data,
    output logic [CHANNELS-1:0]            write_ready,
    input  logic                           load_en,
    input  logic [ADDR_BITS-1:0]           load_addr,
    input  logic [DATA_BITS-1:0]           load_data,
    output logic [DATA_BITS-1:0]           peek_data
`ifdef CHAN_MEM_STATS_EN
    ,
    output logic [15:0]                    reads_committed,
    output logic [15:0]                    writes_committed
`endif
);

    // state   | meaning
    // S_IDLE  | waiting for a request; read wins over write
    // S_WAIT  | latency countdown, access commits on the edge leaving
    // S_RESP  | ready strobe high for this single cycle
    // S_DRAIN | waiting for the served request's valid to drop

    localparam int DEPTH = 1 << ADDR_BITS;
    localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((LATENCY >= 2) ? LATENCY - 2 : 0);
    localparam bit DIRECT = (LATENCY == 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_DRAIN} state_t;

    state_t               state_q  [CHANNELS];
    logic [CHANNELS-1:0]  op_wr_q;
    logic [ADDR_BITS-1:0] addr_q   [CHANNELS];
    logic [DATA_BITS-1:0] wdata_q  [CHANNELS];
    logic [CNT_W-1:0]     cnt_q    [CHANNELS];
    logic [DATA_BITS-1:0] rdata_q  [CHANNELS];
    logic [CHANNELS-1:0]  rd_ready_q;
    logic [CHANNELS-1:0]  wr_ready_q;
    logic [DATA_BITS-1:0] mem_q    [DEPTH];

    logic [ADDR_BITS-1:0] rd_addr_w [CHANNELS];
    logic [ADDR_BITS-1:0] wr_addr_w [CHANNELS];
    logic [DATA_BITS-1:0] wr_data_w [CHANNELS];
    logic [CHANNELS-1:0]  req_rd;
    logic [CHANNELS-1:0]  req_wr;

    logic [CHANNELS-1:0]  cmt_rd;
    logic [CHANNELS-1:0]  cmt_wr;
    logic [ADDR_BITS-1:0] cmt_addr [CHANNELS];
    logic [DATA_BITS-1:0] cmt_data [CHANNELS];

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        assign rd_addr_w[g] = read_address[g*ADDR_BITS +: ADDR_BITS];
        assign wr_addr_w[g] = write_address[g*ADDR_BITS +: ADDR_BITS];
        assign wr_data_w[g] = write_data[g*DATA_BITS +: DATA_BITS];
        assign req_rd[g]    = (state_q[g] == S_IDLE) && read_valid[g];
        assign req_wr[g]    = (state_q[g] == S_IDLE) && !read_valid[g] && write_valid[g];
        assign read_data[g*DATA_BITS +: DATA_BITS] = rdata_q[g];
    end

    // Commit decode: with LATENCY=1 the access commits straight from IDLE using the live request.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            cmt_rd[c]   = 1'b0;
            cmt_wr[c]   = 1'b0;
            cmt_addr[c] = addr_q[c];
            cmt_data[c] = wdata_q[c];
            if (DIRECT) begin
                if (req_rd[c] || req_wr[c]) begin
                    cmt_rd[c]   = req_rd[c];
                    cmt_wr[c]   = req_wr[c];
                    cmt_addr[c] = req_rd[c] ? rd_addr_w[c] : wr_addr_w[c];
                    cmt_data[c] = wr_data_w[c];
                end
            end else if ((state_q[c] == S_WAIT) && (cnt_q[c] == '0)) begin
                cmt_rd[c] = !op_wr_q[c];
                cmt_wr[c] = op_wr_q[c];
            end
            if (reset) begin
                cmt_rd[c] = 1'b0;
                cmt_wr[c] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ready_q <= '0;
            wr_ready_q <= '0;
            op_wr_q    <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                state_q[c] <= S_IDLE;
                addr_q[c]  <= '0;
                wdata_q[c] <= '0;
                cnt_q[c]   <= '0;
                rdata_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                rd_ready_q[c] <= cmt_rd[c];
                wr_ready_q[c] <= cmt_wr[c];
                if (cmt_rd[c]) begin
                    rdata_q[c] <= mem_q[cmt_addr[c]];
                end
                case (state_q[c])
                    S_IDLE: begin
                        if (req_rd[c] || req_wr[c]) begin
                            op_wr_q[c] <= req_wr[c];
                            addr_q[c]  <= req_rd[c] ? rd_addr_w[c] : wr_addr_w[c];
                            wdata_q[c] <= wr_data_w[c];
                            cnt_q[c]   <= CNT_LOAD;
                            state_q[c] <= DIRECT ? S_RESP : S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (cnt_q[c] == '0) begin
                            state_q[c] <= S_RESP;
                        end else begin
                            cnt_q[c] <= cnt_q[c] - 1'b1;
                        end
                    end
                    S_RESP: begin
                        state_q[c] <= S_DRAIN;
                    end
                    S_DRAIN: begin
                        if (op_wr_q[c] ? !write_valid[c] : !read_valid[c]) begin
                            state_q[c] <= S_IDLE;
                        end
                    end
                    default: begin
                        state_q[c] <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // Later channels overwrite earlier ones on the same address; the backdoor load is last and wins.
    always_ff @(posedge clk) begin
        for (int c = 0; c < CHANNELS; c++) begin
            if (cmt_wr[c]) begin
                mem_q[cmt_addr[c]] <= cmt_data[c];
            end
        end
        if (load_en) begin
            mem_q[load_addr] <= load_data;
        end
    end

    assign peek_data   = mem_q[load_addr];
    assign read_ready  = rd_ready_q;
    assign write_ready = wr_ready_q;

`ifdef CHAN_MEM_STATS_EN
    logic [15:0] rd_cnt_q;
    logic [15:0] wr_cnt_q;

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [31:0] n);
        logic [31:0] s;
        s = {16'h0, a} + n;
        return (s > 32'h0000_FFFF) ? 16'hFFFF : s[15:0];
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            rd_cnt_q <= sat_add(rd_cnt_q, 32'($countones(cmt_rd)));
            wr_cnt_q <= sat_add(wr_cnt_q, 32'($countones(cmt_wr)));
        end
    end

    assign reads_committed  = rd_cnt_q;
    assign writes_committed = wr_cnt_q;
`endif

endmodule
